// File: rtl/gc_refresh_rotation_ctrl.sv
// Rotating refresh controller for three gain-cell banks; user port follows the active bank.
// Optional refresh-done checking is enabled by defining REF_DONE_CHECK_EN.
module gc_refresh_rotation_ctrl #(
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 64,
  parameter int DEPTH      = 128,
  parameter int REF_PERIOD = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              usr_we,
  input  logic              usr_re,
  input  logic [ADDR_W-1:0] usr_addr,
  input  logic [DATA_W-1:0] usr_wdata,
  output logic [DATA_W-1:0] usr_rdata,
  output logic              usr_rvalid,
  input  logic              force_ref,
  input  logic [DATA_W-1:0] bank_rd0,
  input  logic [DATA_W-1:0] bank_rd1,
  input  logic [DATA_W-1:0] bank_rd2,
  input  logic [2:0]        ref_done_in,
  output logic [2:0]        u_we,
  output logic [2:0]        u_re,
  output logic [ADDR_W-1:0] u_write_addr,
  output logic [ADDR_W-1:0] u_read_addr,
  output logic [DATA_W-1:0] u_data_in,
  output logic [2:0]        ref_en,
  output logic [2:0]        start_sr,
  output logic [1:0]        active_bank,
  output logic              ref_busy,
  output logic              ref_err
);

  localparam int TW = $clog2(REF_PERIOD);
  localparam logic [TW-1:0] T_RELOAD = TW'(REF_PERIOD - 1);
  localparam logic [ADDR_W-1:0] C_LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, START, COPY, DONE} state_t;

  state_t            state, state_nx;
  logic [TW-1:0]     timer, timer_nx;
  logic [ADDR_W-1:0] cnt, cnt_nx;
  logic [1:0]        bank, bank_nx, dst, rd_bank;
  logic              rvalid_q;
  logic [2:0]        src_oh;

  assign src_oh = 3'b001 << bank;
  assign dst    = (bank == 2'd2) ? 2'd0 : bank + 2'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      timer    <= T_RELOAD;
      cnt      <= '0;
      bank     <= 2'd0;
      rvalid_q <= 1'b0;
      rd_bank  <= 2'd0;
    end else begin
      state    <= state_nx;
      timer    <= timer_nx;
      cnt      <= cnt_nx;
      bank     <= bank_nx;
      rvalid_q <= usr_re;
      rd_bank  <= bank;
    end
  end

  always_comb begin
    state_nx = state;
    timer_nx = timer;
    cnt_nx   = cnt;
    bank_nx  = bank;
    ref_en   = 3'b000;
    start_sr = 3'b000;
    ref_busy = 1'b0;
    case (state)
      IDLE: begin
        if (timer == '0 || force_ref) state_nx = START;
        else timer_nx = timer - 1'b1;
      end
      START: begin
        start_sr = src_oh;
        ref_en   = src_oh;
        ref_busy = 1'b1;
        cnt_nx   = '0;
        state_nx = COPY;
      end
      COPY: begin
        ref_en   = src_oh;
        ref_busy = 1'b1;
        cnt_nx   = cnt + 1'b1;
        if (cnt == C_LAST) state_nx = DONE;
      end
      DONE: begin
        ref_busy = 1'b1;
        bank_nx  = dst;
        timer_nx = T_RELOAD;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // User traffic always lands on the bank holding the valid image
  assign u_we         = usr_we ? src_oh : 3'b000;
  assign u_re         = usr_re ? src_oh : 3'b000;
  assign u_write_addr = usr_addr;
  assign u_read_addr  = usr_addr;
  assign u_data_in    = usr_wdata;
  assign active_bank  = bank;
  assign usr_rvalid   = rvalid_q;

  always_comb begin
    usr_rdata = '0;
    if (rvalid_q) begin
      case (rd_bank)
        2'd0:    usr_rdata = bank_rd0;
        2'd1:    usr_rdata = bank_rd1;
        2'd2:    usr_rdata = bank_rd2;
        default: usr_rdata = '0;
      endcase
    end
  end

`ifdef REF_DONE_CHECK_EN
  logic [2:0] done_q;
  logic [2:0] dst_oh;
  logic       err_q;

  assign dst_oh = 3'b001 << dst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_q <= 3'b000;
      err_q  <= 1'b0;
    end else begin
      done_q <= ref_done_in;
      if (state == DONE && (ref_done_in & dst_oh) == 3'b000) err_q <= 1'b1;
      if (state == IDLE && |(ref_done_in & ~done_q)) err_q <= 1'b1;
    end
  end

  assign ref_err = err_q;
`else
  logic unused_done;
  assign unused_done = ^ref_done_in;
  assign ref_err     = 1'b0;
`endif

endmodule
